// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared constants and types for counter_ctrl
//
// Purpose: opcode constants, the state codes understood by the counter
// block, and the controller FSM encoding.

package counter_ctrl_pkg;

  // Command opcodes carried on cmd_op; 6 and 7 decode as no-ops.
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_START   = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_CLEAR   = 3'd3;
  localparam logic [2:0] OP_SET_CMP = 3'd4;
  localparam logic [2:0] OP_ACK_IRQ = 3'd5;

  // State codes driven to the counter block.
  localparam logic [7:0] ST_RESET = 8'd0;
  localparam logic [7:0] ST_RUN   = 8'd1;
  localparam logic [7:0] ST_HALT  = 8'd2;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_RUN   = 2'd1,
    FSM_HALT  = 2'd2,
    FSM_CLEAR = 2'd3
  } fsm_e;

  // IDLE and CLEAR both hold the counter in reset.
  function automatic logic [7:0] state_code(fsm_e s);
    case (s)
      FSM_RUN:  return ST_RUN;
      FSM_HALT: return ST_HALT;
      default:  return ST_RESET;
    endcase
  endfunction

endpackage

// File: rtl/counter_ctrl_cmp.sv
// rtl/counter_ctrl_cmp.sv - compare threshold, arm flag and sticky irq
//
// Purpose: holds cmp_value and the armed flag, detects counter >= cmp_value
// while running, and resolves irq set/clear priority.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   in_run           controller FSM is currently in RUN
//   counter          current count from the counter block
//   set_cmp          accepted SET_CMP command, operand on cmp_wdata
//   clear            accepted CLEAR command
//   ack              accepted ACK_IRQ command
//   irq              sticky compare interrupt (registered)
//   hit              combinational pulse: a match that will set irq this edge

module counter_ctrl_cmp #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_run,
  input  logic [CNT_W-1:0] counter,
  input  logic             set_cmp,
  input  logic [CNT_W-1:0] cmp_wdata,
  input  logic             clear,
  input  logic             ack,
  output logic             irq,
  output logic             hit
);

  logic [CNT_W-1:0] cmp_value_q;
  logic             armed_q;

  // CLEAR and a fresh SET_CMP both swallow a same-cycle match, so hit is
  // only reported when the match really lands in irq.
  assign hit = armed_q && in_run && (counter >= cmp_value_q) && !clear && !set_cmp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmp_value_q <= '1;
      armed_q     <= 1'b0;
      irq         <= 1'b0;
    end else if (clear) begin
      armed_q <= 1'b0;
      irq     <= 1'b0;
    end else if (set_cmp) begin
      cmp_value_q <= cmp_wdata;
      armed_q     <= 1'b1;
    end else if (hit) begin
      // Set beats a same-cycle ACK_IRQ.
      armed_q <= 1'b0;
      irq     <= 1'b1;
    end else if (ack) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - command-driven sequencer for the counter block
//
// Purpose: accepts opcode/data commands over a valid/ready handshake and
// drives the counter's state code and interval; raises a sticky compare irq.
// Build option: COUNTER_CTRL_AUTO_HALT_EN - a compare match also moves
// RUN -> HALT on the same edge that sets irq.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready low only during CLEAR)
//   cmd_op, cmd_wdata    opcode and operand
//   counter              current count returned by the counter block
//   state                counter state code (registered)
//   interval             counter interval (registered)
//   irq                  sticky compare interrupt (registered)
//   busy                 high in RUN or CLEAR

module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_wdata,
  input  logic [CNT_W-1:0] counter,
  output logic [7:0]       state,
  output logic [CNT_W-1:0] interval,
  output logic             irq,
  output logic             busy
);

  localparam logic [3:0]       CLR_LOAD = 4'(CLR_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  fsm_e             fsm_q, fsm_d;
  logic [3:0]       clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] interval_d;
  logic             accept;
  logic             do_start, do_halt, do_clear, do_set_cmp, do_ack;
  logic             hit;

  assign cmd_ready  = (fsm_q != FSM_CLEAR);
  assign busy       = (fsm_q == FSM_RUN) || (fsm_q == FSM_CLEAR);
  assign accept     = cmd_valid && cmd_ready;
  assign do_start   = accept && (cmd_op == OP_START);
  assign do_halt    = accept && (cmd_op == OP_HALT);
  assign do_clear   = accept && (cmd_op == OP_CLEAR);
  assign do_set_cmp = accept && (cmd_op == OP_SET_CMP);
  assign do_ack     = accept && (cmd_op == OP_ACK_IRQ);

  counter_ctrl_cmp #(
    .CNT_W(CNT_W)
  ) u_cmp (
    .clk      (clk),
    .resetn   (resetn),
    .in_run   (fsm_q == FSM_RUN),
    .counter  (counter),
    .set_cmp  (do_set_cmp),
    .cmp_wdata(cmd_wdata),
    .clear    (do_clear),
    .ack      (do_ack),
    .irq      (irq),
    .hit      (hit)
  );

  always_comb begin
    fsm_d      = fsm_q;
    clr_cnt_d  = clr_cnt_q;
    interval_d = interval;

    case (fsm_q)
      FSM_IDLE, FSM_HALT: if (do_start) fsm_d = FSM_RUN;
      FSM_RUN:            if (do_halt) fsm_d = FSM_HALT;
      FSM_CLEAR: begin
        // Counter holds CLR_CYCLES..1 while in CLEAR, giving exactly
        // CLR_CYCLES cycles of RESET before returning to IDLE.
        clr_cnt_d = clr_cnt_q - 4'd1;
        if (clr_cnt_q == 4'd1) fsm_d = FSM_IDLE;
      end
      default:            fsm_d = FSM_IDLE;
    endcase

    // A zero interval would stall the counter, so it is promoted to 1.
    if (do_start) interval_d = (cmd_wdata == '0) ? ONE : cmd_wdata;

    if (do_clear) begin
      fsm_d     = FSM_CLEAR;
      clr_cnt_d = CLR_LOAD;
    end

`ifdef COUNTER_CTRL_AUTO_HALT_EN
    if (hit && (fsm_d == FSM_RUN)) fsm_d = FSM_HALT;
`endif
  end

`ifndef COUNTER_CTRL_AUTO_HALT_EN
  logic unused_hit;
  assign unused_hit = hit;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q     <= FSM_IDLE;
      clr_cnt_q <= 4'd0;
      state     <= ST_RESET;
      interval  <= ONE;
    end else begin
      fsm_q     <= fsm_d;
      clr_cnt_q <= clr_cnt_d;
      state     <= state_code(fsm_d);
      interval  <= interval_d;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl

module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int W   = 32;
  localparam int CLR = 2;
`ifdef COUNTER_CTRL_AUTO_HALT_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [W-1:0]  cmd_wdata = '0;
  logic [W-1:0]  counter = '0;
  logic          cmd_ready;
  logic [7:0]    state;
  logic [W-1:0]  interval;
  logic          irq;
  logic          busy;

  counter_ctrl #(.CNT_W(W), .CLR_CYCLES(CLR)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .counter(counter), .state(state),
    .interval(interval), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 run, 2 halt, 3 clearing.
  int              m_mode, m_left;
  longint unsigned m_interval, m_cmp;
  bit              m_irq, m_armed;

  always @(posedge clk or negedge resetn) begin
    bit acc, match;
    if (!resetn) begin
      m_mode = 0; m_left = 0; m_interval = 1; m_cmp = 64'hFFFF_FFFF;
      m_irq = 0; m_armed = 0;
    end else begin
      acc   = cmd_valid && (m_mode != 3);
      match = m_armed && (m_mode == 1) && (longint'(counter) >= m_cmp);
      if (acc && cmd_op == 3'd3) match = 0;
      if (acc && cmd_op == 3'd4) match = 0;
      // irq / compare
      if (match) begin m_irq = 1; m_armed = 0; end
      if (acc && cmd_op == 3'd5 && !match) m_irq = 0;
      if (acc && cmd_op == 3'd4) begin m_cmp = longint'(cmd_wdata); m_armed = 1; end
      if (acc && cmd_op == 3'd3) begin m_irq = 0; m_armed = 0; end
      // mode / interval
      if (m_mode == 3) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end else if (acc) begin
        if (cmd_op == 3'd1) begin
          m_interval = (cmd_wdata == 0) ? 1 : longint'(cmd_wdata);
          m_mode = 1;
        end else if (cmd_op == 3'd2 && m_mode == 1) begin
          m_mode = 2;
        end else if (cmd_op == 3'd3) begin
          m_mode = 3; m_left = CLR;
        end
      end
      if (AUTO == 1 && match && m_mode == 1) m_mode = 2;
    end
  end

  function automatic logic [63:0] exp_state();
    return (m_mode == 1) ? 64'd1 : (m_mode == 2) ? 64'd2 : 64'd0;
  endfunction

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_state", 64'(state), exp_state());
      check("cyc_interval", 64'(interval), m_interval);
      check("cyc_irq", 64'(irq), 64'(m_irq));
      check("cyc_ready", 64'(cmd_ready), 64'(m_mode != 3));
      check("cyc_busy", 64'(busy), 64'(m_mode == 1 || m_mode == 3));
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] c);
    cmd_valid = v; cmd_op = op; cmd_wdata = d; counter = c;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    chk_on = 1;
    // reset values
    check("rst_state", 64'(state), 64'd0);
    check("rst_interval", 64'(interval), 64'd1);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    drive(1, OP_NOP, 0, 0);
    // start, halt, resume
    drive(1, OP_START, 4, 0);
    check("start_state", 64'(state), 64'd1);
    check("start_interval", 64'(interval), 64'd4);
    check("start_busy", 64'(busy), 64'd1);
    drive(1, OP_HALT, 0, 0);
    check("halt_state", 64'(state), 64'd2);
    check("halt_busy", 64'(busy), 64'd0);
    drive(1, OP_START, 3, 0);
    check("resume_state", 64'(state), 64'd1);
    check("resume_interval", 64'(interval), 64'd3);
    // clear window with START held
    drive(1, OP_CLEAR, 0, 0);
    check("clr0_state", 64'(state), 64'd0);
    check("clr0_ready", 64'(cmd_ready), 64'd0);
    drive(1, OP_START, 5, 0);
    check("clr1_state", 64'(state), 64'd0);
    check("clr1_ready", 64'(cmd_ready), 64'd0);
    drive(1, OP_START, 5, 0);
    check("clr2_ready", 64'(cmd_ready), 64'd1);
    check("clr2_interval", 64'(interval), 64'd3);
    drive(1, OP_START, 5, 0);
    check("post_clr_state", 64'(state), 64'd1);
    check("post_clr_interval", 64'(interval), 64'd5);
    // halt in idle is ignored
    drive(1, OP_CLEAR, 0, 0);
    drive(1, OP_NOP, 0, 0);
    drive(1, OP_NOP, 0, 0);
    drive(1, OP_HALT, 0, 0);
    check("idle_halt_state", 64'(state), 64'd0);
    // compare sequence
    drive(1, OP_SET_CMP, 100, 98);
    drive(1, OP_START, 1, 98);
    check("cmp_run_state", 64'(state), 64'd1);
    drive(0, OP_NOP, 0, 99);
    check("cmp_99_irq", 64'(irq), 64'd0);
    drive(0, OP_NOP, 0, 100);
    check("cmp_100_irq", 64'(irq), 64'd1);
    check("cmp_100_state", 64'(state), (AUTO == 1) ? 64'd2 : 64'd1);
    drive(0, OP_NOP, 0, 101);
    drive(0, OP_NOP, 0, 50);
    check("cmp_sticky_irq", 64'(irq), 64'd1);
    drive(1, OP_ACK_IRQ, 0, 50);
    check("cmp_ack_irq", 64'(irq), 64'd0);
    drive(0, OP_NOP, 0, 101);
    check("cmp_norefire_irq", 64'(irq), 64'd0);
    // ACK on match cycle: set wins
    drive(1, OP_START, 1, 50);
    drive(1, OP_SET_CMP, 100, 50);
    drive(1, OP_ACK_IRQ, 0, 100);
    check("ack_match_irq", 64'(irq), 64'd1);
    // CLEAR on match cycle: clear wins
    drive(1, OP_START, 1, 50);
    drive(1, OP_SET_CMP, 100, 50);
    drive(1, OP_CLEAR, 0, 100);
    check("clr_match_irq", 64'(irq), 64'd0);
    check("clr_match_state", 64'(state), 64'd0);
    drive(0, OP_NOP, 0, 0);
    drive(0, OP_NOP, 0, 0);
    // START with zero interval
    drive(1, OP_START, 0, 5);
    check("start0_interval", 64'(interval), 64'd1);
    // SET_CMP on a match cycle discards the old match
    drive(1, OP_SET_CMP, 10, 5);
    drive(1, OP_SET_CMP, 200, 20);
    check("setcmp_match_irq", 64'(irq), 64'd0);
    drive(1, 3'd6, 0, 20);
    check("op6_state", 64'(state), 64'd1);
    check("setcmp_after_irq", 64'(irq), 64'd0);
    drive(1, 3'd7, 0, 200);
    check("new_cmp_irq", 64'(irq), 64'd1);
    check("new_cmp_state", 64'(state), (AUTO == 1) ? 64'd2 : 64'd1);
    drive(0, OP_NOP, 0, 0);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Command-driven sequencer for the free-running `counter` block. It accepts opcode/data commands from the CPU-side bus over a valid/ready handshake, and drives the counter's `state` code (RESET/RUN/HALT) and `interval` inputs. It also watches the returned `counter` value against a programmable compare threshold and raises a sticky interrupt. It sits between the bus decoder and `counter`, and is the only agent permitted to drive `counter`'s control inputs.

## Interface
- `CNT_W`, 32: width of `interval`, `counter` and compare value.
- `CLR_CYCLES`, 2: number of cycles RESET is held on a CLEAR command; legal range 1..15.
- `clk`  in  1  single clock; all logic is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  opcode: 0 NOP, 1 START, 2 HALT, 3 CLEAR, 4 SET_CMP, 5 ACK_IRQ; 6–7 are treated as NOP.
- `cmd_wdata`  in  CNT_W  operand for START (interval) and SET_CMP (threshold).
- `counter`  in  CNT_W  current count from `counter`.
- `state`  out  8  to `counter`: 0 RESET, 1 RUN, 2 HALT.
- `interval`  out  CNT_W  to `counter`.
- `irq`  out  1  sticky compare interrupt.
- `busy`  out  1  high in RUN or CLEAR.

## Operation
- FSM states are IDLE, RUN, HALT and CLEAR. The `state` output is 0 in IDLE and CLEAR, 1 in RUN, and 2 in HALT.
- A command is accepted on a cycle where `cmd_valid && cmd_ready`. `cmd_ready` = 0 in CLEAR and 1 otherwise. Each command takes effect on the registered outputs the following cycle.
- START:
  - Loads `interval` from `cmd_wdata`; a value of 0 is loaded as 1.
  - IDLE or HALT → RUN.
  - In RUN, it only updates `interval` and the state is unchanged.
- HALT: RUN → HALT. It is ignored in any other state.
- CLEAR:
  - Any state → CLEAR. Reloads a down-counter with CLR_CYCLES, clears `irq`, and disarms compare.
  - CLEAR exits to IDLE when the down-counter reaches 0, so `state` = 0 for exactly CLR_CYCLES cycles.
  - `interval` is retained.
- SET_CMP: `cmp_value` ← `cmd_wdata` and the compare is armed. Accepted in every state except CLEAR.
- ACK_IRQ: clears `irq`.
- Compare rule: when armed, in RUN, and `counter >= cmp_value` (unsigned), set `irq` and disarm. The compare fires once per SET_CMP.
- Simultaneous events:
  - A match and ACK_IRQ in the same cycle: set wins, and `irq` stays 1.
  - A match and CLEAR in the same cycle: CLEAR wins, and `irq` = 0.
  - A match and SET_CMP in the same cycle: the new value is armed and the old match is discarded.
- Assertion of `resetn` in any state forces the reset values asynchronously. In-flight CLEAR and armed compare are dropped.

## Timing
- All outputs are registered except `cmd_ready` and `busy`, which decode the FSM register.
- Reset values:
  - `state` = 0 (IDLE), `interval` = 1, `irq` = 0, `cmd_ready` = 1, `busy` = 0.
  - `cmp_value` = all ones, compare disarmed.
- Command latency: accepted at edge N, visible on `state`/`interval` after edge N+1.
- Compare latency: `counter` sampled at edge N meets the condition → `irq` = 1 after edge N+1.
- CLEAR accepted at edge N: `state` = 0 for CLR_CYCLES cycles. `cmd_ready` returns to 1 in the cycle after the last RESET cycle.

## Configuration
- `COUNTER_CTRL_AUTO_HALT_EN` defined: the cycle a compare match sets `irq`, the FSM also moves RUN → HALT, so `state` = 2 together with `irq` = 1.
- Undefined: a match only raises `irq`, and the FSM stays in RUN.

## Structure
- Shared package `counter_ctrl_pkg` holds:
  - opcode constants (OP_NOP..OP_ACK_IRQ);
  - counter state codes (ST_RESET = 0, ST_RUN = 1, ST_HALT = 2);
  - FSM state encodings.
- `counter` and its bench use the same state codes.
- One sub-module, `counter_ctrl_cmp`, holds `cmp_value`, the armed flag, and the `irq` set/clear priority. Its match-pulse output feeds the FSM for auto-halt.

## Test plan
- **Reset and start:** release reset → `state` = 0, `interval` = 1, `irq` = 0. Issue START with `cmd_wdata` = 4 → `state` = 1 and `interval` = 4 one cycle later.
- **Halt, resume, illegal halt:** RUN, then HALT → `state` = 2. START with 3 → `state` = 1, `interval` = 3. HALT while in IDLE → no change.
- **CLEAR, CLR_CYCLES = 2:** CLEAR in RUN → `state` = 0 and `cmd_ready` = 0 for 2 cycles. `cmd_valid` held high with START during that window is not accepted, then is accepted on the following cycle.
- **Compare:** SET_CMP 100, START 1, `counter` driven 98, 99, 100, 101 → `irq` rises one cycle after 100 is sampled. It stays 1 after `counter` returns below 100, until ACK_IRQ. There is no re-fire at 101.
- **Same-cycle priorities:** ACK_IRQ on the match cycle → `irq` = 1. CLEAR on the match cycle → `irq` = 0. START with `cmd_wdata` = 0 → `interval` = 1.
- **With COUNTER_CTRL_AUTO_HALT_EN:** the match at 100 gives `state` = 2 and `irq` = 1 on the same cycle. Without the macro, `state` stays 1.
